// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//
// Stall sequencer for the five-stage pipeline (IF, ID, EXE, MEM, WB).
// It combines two stall sources:
//   * load-use / RAW hazard detection between the ID-stage operands and the
//     EXE/MEM destinations (the rule depends on whether forwarding is enabled);
//   * a memory wait sequencer that freezes the whole pipeline for MEM_LAT-1
//     cycles while a MEM-stage load/store completes, followed by one release
//     cycle in which the access retires.
// A saturating counter records every cycle in which the front end is held.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   fwd_en          forwarding enabled (selects the hazard rule)
//   id_src1/2       ID-stage source registers, qualified by id_use_src1 / id_two_src
//   exe_dest        EXE destination, with exe_wb_en and exe_mem_r_en (load)
//   mem_dest        MEM destination, with mem_wb_en
//   mem_acc         MEM-stage instruction is a load or store
//   freeze_front    hold PC and IF/ID
//   freeze_back     hold ID/EXE, EXE/MEM and MEM/WB
//   bubble_id_exe   clear the ID/EXE control bits
//   mem_busy        wait sequencer is in its WAIT state (debug view of the FSM)
//   stall_cnt       saturating count of cycles with freeze_front set
//
// There is no valid/ready handshake in this block: every output is a
// level-sensitive, same-cycle function of the FSM state and the stage inputs.
module hazard_stall_controller #(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             id_use_src1,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_acc,
    output logic             freeze_front,
    output logic             freeze_back,
    output logic             bubble_id_exe,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // The trigger cycle itself is the first frozen cycle, so WAIT only has to
    // cover the remaining MEM_LAT-2 frozen cycles before the release cycle.
    localparam logic [3:0] WLOAD   = 4'(MEM_LAT - 2);
    localparam logic       LAT_GT1 = (MEM_LAT > 1);

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic m1_exe, m2_exe, m1_mem, m2_mem;
    logic haz, mtrig, mem_wait;

    always_comb begin
        m1_exe = id_use_src1 && (id_src1 == exe_dest);
        m2_exe = id_two_src  && (id_src2 == exe_dest);
        m1_mem = id_use_src1 && (id_src1 == mem_dest);
        m2_mem = id_two_src  && (id_src2 == mem_dest);

        // With forwarding only a load in EXE cannot be bypassed in time;
        // without it any pending write in EXE or MEM must drain first.
        if (fwd_en) begin
            haz = exe_mem_r_en && (m1_exe || m2_exe);
        end else begin
            haz = (exe_wb_en && (m1_exe || m2_exe)) ||
                  (mem_wb_en && (m1_mem || m2_mem));
        end

        // mem_acc is only looked at in IDLE, so the release cycle of one
        // access can never retrigger on the same instruction.
        mtrig    = (state_q == S_IDLE) && mem_acc && LAT_GT1;
        mem_wait = mtrig || ((state_q == S_WAIT) && (wcnt_q != 4'd0));

        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (mtrig) begin
                    state_d = S_WAIT;
                    wcnt_d  = WLOAD;
                end
            end
            S_WAIT: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                wcnt_d  = 4'd0;
            end
        endcase

        // Outputs are forced low while reset is held, even though the hazard
        // and trigger terms are otherwise purely combinational on inputs.
        freeze_back   = !rst && mem_wait;
        freeze_front  = !rst && (mem_wait || haz);
        // No bubble while the back end is frozen: the hazard is re-evaluated
        // once the freeze lifts.
        bubble_id_exe = !rst && haz && !mem_wait;
        mem_busy      = !rst && (state_q == S_WAIT);

        stall_cnt_d = stall_cnt_q;
        if (freeze_front && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    logic       clk;
    logic       rst;
    logic       fwd_en;
    logic [3:0] id_src1, id_src2;
    logic       id_two_src, id_use_src1;
    logic [3:0] exe_dest;
    logic       exe_wb_en, exe_mem_r_en;
    logic [3:0] mem_dest;
    logic       mem_wb_en, mem_acc;

    // instance a: MEM_LAT=4, CNT_W=16 ; instance b: MEM_LAT=1, CNT_W=4
    logic        ff_a, fb_a, bub_a, busy_a;
    logic [15:0] cnt_a;
    logic        ff_b, fb_b, bub_b, busy_b;
    logic [3:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    hazard_stall_controller #(.MEM_LAT(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_use_src1(id_use_src1),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_acc(mem_acc),
        .freeze_front(ff_a), .freeze_back(fb_a), .bubble_id_exe(bub_a),
        .mem_busy(busy_a), .stall_cnt(cnt_a)
    );

    hazard_stall_controller #(.MEM_LAT(1), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_use_src1(id_use_src1),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_acc(mem_acc),
        .freeze_front(ff_b), .freeze_back(fb_b), .bubble_id_exe(bub_b),
        .mem_busy(busy_b), .stall_cnt(cnt_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each memory access is described by its start cycle: frozen for cycles
    // start .. start+LAT-2, released at start+LAT-1, busy for start+1 .. release.
    int t;
    bit act   [2];
    int st    [2];
    int rel   [2];
    int cnt   [2];
    int lat   [2] = '{4, 1};
    int cmax  [2] = '{65535, 15};

    function automatic bit reads(input logic [3:0] x);
        return (id_use_src1 && id_src1 == x) || (id_two_src && id_src2 == x);
    endfunction

    function automatic bit m_haz();
        if (fwd_en) return exe_mem_r_en && reads(exe_dest);
        return (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
    endfunction

    function automatic bit m_in_access(input int k);
        return act[k] && t <= rel[k];
    endfunction

    function automatic bit m_starts(input int k);
        return !m_in_access(k) && mem_acc && lat[k] > 1;
    endfunction

    function automatic bit m_wait(input int k);
        return (act[k] && t < rel[k]) || m_starts(k);
    endfunction

    function automatic bit m_busy(input int k);
        return act[k] && t > st[k] && t <= rel[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit w, h;
            logic [31:0] o_ff, o_fb, o_bub, o_busy, o_cnt;
            w = m_wait(k);
            h = m_haz();
            o_ff   = (k == 0) ? 32'(ff_a)   : 32'(ff_b);
            o_fb   = (k == 0) ? 32'(fb_a)   : 32'(fb_b);
            o_bub  = (k == 0) ? 32'(bub_a)  : 32'(bub_b);
            o_busy = (k == 0) ? 32'(busy_a) : 32'(busy_b);
            o_cnt  = (k == 0) ? 32'(cnt_a)  : 32'(cnt_b);
            chk($sformatf("freeze_front[%0d]", k), o_ff,  32'(!rst && (w || h)));
            chk($sformatf("freeze_back[%0d]", k),  o_fb,  32'(!rst && w));
            chk($sformatf("bubble[%0d]", k),       o_bub, 32'(!rst && h && !w));
            chk($sformatf("mem_busy[%0d]", k),     o_busy, 32'(!rst && m_busy(k)));
            chk($sformatf("stall_cnt[%0d]", k),    o_cnt, rst ? 32'd0 : 32'(cnt[k]));
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                act[k] = 1'b0;
                cnt[k] = 0;
            end else begin
                if ((m_wait(k) || m_haz()) && cnt[k] < cmax[k]) cnt[k]++;
                if (m_starts(k)) begin
                    act[k] = 1'b1;
                    st[k]  = t;
                    rel[k] = t + lat[k] - 1;
                end
            end
        end
        t++;
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are applied 1 time unit after a rising edge; one call of cyc
    // checks the cycle at the falling edge and steps the model on the next edge.
    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic clear_inputs();
        fwd_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_use_src1 = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_dest = 0; mem_wb_en = 0; mem_acc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic set_fwd_load_use();
        fwd_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3;
        id_src1 = 3; id_use_src1 = 1; id_src2 = 9; id_two_src = 0;
        mem_dest = 7; mem_wb_en = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    int fb_seen, bub_frozen;

    initial begin
        t = 0;
        for (int k = 0; k < 2; k++) begin
            act[k] = 0; st[k] = 0; rel[k] = 0; cnt[k] = 0;
        end
        clear_inputs();
        rst = 1'b1;
        #1;
        mem_acc = 1; set_fwd_load_use();
        #1;
        // reset state: outputs low even with hazard and access inputs active
        chk("rst_ff",   32'(ff_a),   32'd0);
        chk("rst_bub",  32'(bub_a),  32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_cnt",  32'(cnt_a),  32'd0);
        clear_inputs();
        @(posedge clk); #1;
        do_reset();

        // forwarded load-use hazard: one stall cycle with bubble
        set_fwd_load_use();
        #1;
        chk("lu_ff",  32'(ff_a),  32'd1);
        chk("lu_bub", 32'(bub_a), 32'd1);
        chk("lu_fb",  32'(fb_a),  32'd0);
        cyc();
        clear_inputs();
        #1;
        chk("lu_cnt", 32'(cnt_a), 32'd1);
        chk("lu_ff_after", 32'(ff_a), 32'd0);
        cyc();

        // no-forward RAW hazard against the MEM stage via src2
        fwd_en = 0; mem_wb_en = 1; mem_dest = 5; id_src2 = 5; id_two_src = 1;
        id_src1 = 1; id_use_src1 = 1; exe_dest = 8; exe_wb_en = 1;
        #1;
        chk("raw_ff",  32'(ff_a),  32'd1);
        chk("raw_bub", 32'(bub_a), 32'd1);
        cyc();
        id_two_src = 0;
        #1;
        chk("raw_nosrc2_ff", 32'(ff_a), 32'd0);
        cyc();
        // with forwarding the same MEM writeback is bypassed
        id_two_src = 1; fwd_en = 1;
        #1;
        chk("raw_fwd_ff", 32'(ff_a), 32'd0);
        cyc();
        clear_inputs();

        // memory wait, MEM_LAT=4, mem_acc held
        do_reset();
        mem_acc = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mw_fb%0d", i),   32'(fb_a),   32'(i < 3));
            chk($sformatf("mw_busy%0d", i), 32'(busy_a), 32'(i > 0));
            chk($sformatf("mw_b_fb%0d", i), 32'(fb_b),   32'd0);
            cyc();
        end
        #1;
        chk("mw_cnt", 32'(cnt_a), 32'd3);
        chk("mw_retrig", 32'(fb_a), 32'd1);
        mem_acc = 0;
        cyc();

        // back-to-back accesses with a load-use hazard during the first wait
        do_reset();
        fb_seen = 0; bub_frozen = 0;
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            if (i < 3) set_fwd_load_use();
            mem_acc = (i == 0 || i == 3 || i == 4) ? 1'b1 : 1'b0;
            #1;
            fb_seen    += fb_a;
            bub_frozen += (bub_a && fb_a);
            if (i < 3) chk($sformatf("b2b_bub%0d", i), 32'(bub_a), 32'd0);
            cyc();
        end
        chk("b2b_freeze_total", 32'(fb_seen), 32'd6);
        chk("b2b_bub_frozen", 32'(bub_frozen), 32'd0);
        clear_inputs();

        // asynchronous reset during WAIT with wcnt=1
        do_reset();
        mem_acc = 1;
        cyc();
        mem_acc = 0;
        cyc();
        mem_acc = 1;
        #2;
        chk("pre_rst_busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_ff",   32'(ff_a),   32'd0);
        chk("arst_fb",   32'(fb_a),   32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_cnt",  32'(cnt_a),  32'd0);
        cyc();
        rst = 1'b0;
        mem_acc = 0;
        #1;
        chk("arst_no_resume", 32'(fb_a), 32'd0);
        cyc();

        // counter saturation on the CNT_W=4 instance
        do_reset();
        fwd_en = 0; exe_wb_en = 1; exe_dest = 6; id_src1 = 6; id_use_src1 = 1;
        for (int i = 0; i < 20; i++) cyc();
        #1;
        chk("sat_cnt_b", 32'(cnt_b), 32'd15);
        chk("sat_cnt_a", 32'(cnt_a), 32'd20);
        clear_inputs();
        cyc();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 39) == 0);
            fwd_en       = 1'($urandom_range(0, 1));
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            id_use_src1  = 1'($urandom_range(0, 1));
            exe_dest     = 4'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_dest     = 4'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_acc      = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences pipeline stalls for the five-stage ARM core (IF, ID, EXE, MEM, WB).
- Combines two stall sources:
  - load-use / RAW hazard detection, which works alongside the forwarding mux-select logic;
  - a multi-cycle data-memory wait sequencer that freezes the whole pipeline while a MEM-stage access completes.
- Drives the PC/IF-ID freeze, the back-end freeze and the ID/EXE bubble.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MEM_LAT, 4, total cycles a MEM-stage load/store occupies; legal values 1..15; 1 means no wait.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- fwd_en  input  1  forwarding enabled; selects the hazard rule.
- id_src1  input  4  ID-stage first source register.
- id_src2  input  4  ID-stage second source register.
- id_two_src  input  1  ID instruction reads src2 (for example a register operand or STR).
- id_use_src1  input  1  ID instruction reads src1 (0 for MOV/MVN or branch).
- exe_dest  input  4  EXE-stage destination register.
- exe_wb_en  input  1  EXE-stage writeback enable.
- exe_mem_r_en  input  1  EXE-stage instruction is a load.
- mem_dest  input  4  MEM-stage destination register.
- mem_wb_en  input  1  MEM-stage writeback enable.
- mem_acc  input  1  MEM-stage instruction is a load or store.
- freeze_front  output  1  hold PC and the IF/ID register.
- freeze_back  output  1  hold the ID/EXE, EXE/MEM and MEM/WB registers.
- bubble_id_exe  output  1  clear the ID/EXE control bits (insert a NOP).
- mem_busy  output  1  memory wait sequence in progress.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- While rst is high:
  - state=IDLE, wcnt=0, stall_cnt=0;
  - all 1-bit outputs forced to 0.
- Operand match rules (combinational):
  - m1 = id_use_src1 && id_src1==X;
  - m2 = id_two_src && id_src2==X.
- Hazard rule (haz), combinational:
  - fwd_en=1: haz = exe_mem_r_en && (m1||m2) with X=exe_dest.
  - fwd_en=0: haz = (exe_wb_en && (m1||m2) with X=exe_dest) || (mem_wb_en && (m1||m2) with X=mem_dest).
  - Register 15 and exe_dest==mem_dest cases get no special treatment.
- Memory wait FSM: a 2-state FSM (IDLE, WAIT) with a 4-bit down-counter wcnt.
  - mtrig = state==IDLE && mem_acc && MEM_LAT>1.
  - IDLE with mtrig: go to WAIT, load wcnt=MEM_LAT-2.
  - WAIT with wcnt!=0: decrement wcnt, stay in WAIT.
  - WAIT with wcnt==0 (release cycle): go to IDLE. No freeze in this cycle, so the access retires.
  - mem_acc is ignored during the release cycle, so the same instruction cannot retrigger.
  - A memory instruction following immediately retriggers in the next IDLE cycle.
  - Freeze duration is exactly MEM_LAT-1 cycles per access, then one release cycle.
  - MEM_LAT=1: the FSM never leaves IDLE.
- Outputs (combinational from state and inputs):
  - mem_wait = mtrig || (state==WAIT && wcnt!=0).
  - freeze_back = mem_wait.
  - freeze_front = mem_wait || haz.
  - bubble_id_exe = haz && !mem_wait. No bubble is inserted while the back end is frozen; the hazard is re-evaluated after the freeze.
  - mem_busy = state==WAIT.
- Stall counter:
  - stall_cnt increments on each clock edge where freeze_front=1;
  - saturates at 2^CNT_W-1;
  - cleared only by rst.
- Reset asserted mid-sequence: returns to IDLE immediately and asynchronously. The aborted access is not resumed.

Test Plan:
- Forwarded load-use hazard:
  - stimulus: fwd_en=1, exe_mem_r_en=1, exe_dest=3, id_src1=3, id_use_src1=1;
  - response: freeze_front=1 and bubble_id_exe=1 for 1 cycle, freeze_back=0, stall_cnt +1.
- No-forward RAW hazard:
  - stimulus: fwd_en=0, mem_wb_en=1, mem_dest=5, id_src2=5, id_two_src=1;
  - response: freeze_front=1, bubble=1.
  - Same stimulus with id_two_src=0: no stall.
- Memory wait, MEM_LAT=4:
  - stimulus: mem_acc=1 held;
  - response: freeze_back=1 for exactly 3 cycles, mem_busy=1 for cycles 2..4, release cycle with freeze_back=0, stall_cnt=3.
- Back-to-back access plus hazard:
  - stimulus: two consecutive memory instructions, with haz=1 during the first wait;
  - response: bubble_id_exe held 0 while frozen; the second access retriggers right after the release cycle (total 6 freeze cycles).
- Reset during WAIT:
  - stimulus: rst pulse at wcnt=1;
  - response: all outputs 0 asynchronously, state=IDLE, stall_cnt=0.
- Counter saturation:
  - stimulus: CNT_W=4, continuous haz for 20 cycles;
  - response: stall_cnt stops at 15.
